// File: rtl/store_pkg.sv
// Shared encodings and helpers for the store alignment queue.
package store_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] MD_NORM = 2'd0;
    localparam logic [1:0] MD_SWL  = 2'd1;
    localparam logic [1:0] MD_SWR  = 2'd2;

    function automatic int lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational store alignment: shifts register data into its byte lanes,
// builds byte enables and flags illegal (misaligned / reserved) requests.
module store_lane_align
    import store_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int LANES = lanes(DATA_W),
    localparam int OFF_W = $clog2(LANES)
) (
    input  logic [OFF_W-1:0]  addr_lo,
    input  logic [31:0]       data,
    input  logic [1:0]        size,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] lane_data,
    output logic [LANES-1:0]  lane_strb,
    output logic              illegal
);

    localparam int NW = DATA_W / 32;

    logic [1:0]  o;
    logic [31:0] d32;
    logic [31:0] dm;
    logic [3:0]  s4;
    logic        w_sel;

    assign o = addr_lo[1:0];

    always_comb begin
        d32     = '0;
        s4      = '0;
        illegal = 1'b0;
        case (mode)
            MD_NORM: begin
                case (size)
                    SZ_BYTE: begin
                        d32 = data << {o, 3'b000};
                        s4  = 4'b0001 << o;
                    end
                    SZ_HALF: begin
                        illegal = o[0];
                        d32     = data << {o, 3'b000};
                        s4      = 4'b0011 << o;
                    end
                    SZ_WORD: begin
                        illegal = (o != 2'd0);
                        d32     = data;
                        s4      = 4'b1111;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            // SWL keeps the upper (o+1) bytes of rt, landing them in the low lanes
            MD_SWL: begin
                d32 = data >> {~o, 3'b000};
                s4  = 4'b1111 >> ~o;
            end
            MD_SWR: begin
                d32 = data << {o, 3'b000};
                s4  = 4'b1111 << o;
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        dm = '0;
        for (int i = 0; i < 4; i++) begin
            dm[8*i +: 8] = s4[i] ? d32[8*i +: 8] : 8'h00;
        end
    end

    if (NW > 1) begin : g_wide
        assign w_sel = addr_lo[OFF_W-1];
    end else begin : g_narrow
        assign w_sel = 1'b0;
    end

    for (genvar k = 0; k < NW; k++) begin : g_word
        assign lane_data[32*k +: 32] = (int'(w_sel) == k) ? dm : 32'h0;
        assign lane_strb[4*k +: 4]   = (int'(w_sel) == k) ? s4 : 4'h0;
    end

endmodule

// File: rtl/store_align_queue.sv
// Store queue: aligns incoming register stores to the memory bus and buffers
// them in a DEPTH-entry FIFO; illegal requests are dropped with an ades pulse.
module store_align_queue
    import store_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    localparam int LANES = lanes(DATA_W),
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    input  logic [1:0]        req_mode,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic [LANES-1:0]  out_strb,
    output logic              ades,
    output logic [CNT_W-1:0]  count
);

    localparam int OFF_W = $clog2(LANES);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(LANES - 1);

    logic [DATA_W-1:0] al_data;
    logic [LANES-1:0]  al_strb;
    logic              al_illegal;

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [LANES-1:0]  mem_strb [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             accept;
    logic             push;
    logic             pop;

    store_lane_align #(.DATA_W(DATA_W)) u_align (
        .addr_lo   (req_addr[OFF_W-1:0]),
        .data      (req_data),
        .size      (req_size),
        .mode      (req_mode),
        .lane_data (al_data),
        .lane_strb (al_strb),
        .illegal   (al_illegal)
    );

    assign req_ready = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign accept    = req_valid & req_ready;
    assign push      = accept & ~al_illegal;
    assign pop       = out_valid & out_ready;

    assign out_addr = mem_addr[rd_ptr];
    assign out_data = mem_data[rd_ptr];
    assign out_strb = mem_strb[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ades   <= 1'b0;
        end else begin
            // ades reports a consumed illegal request even when flush wins
            ades <= accept & al_illegal;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= req_addr & ADDR_MASK;
            mem_data[wr_ptr] <= al_data;
            mem_strb[wr_ptr] <= al_strb;
        end
    end

endmodule

// File: tb/tb_store_align_queue.sv
// Bench for store_align_queue: 32-bit and 64-bit instances driven in parallel,
// checked each cycle against a byte-level queue model plus literal vectors.
module tb_store_align_queue;
    import store_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_size = '0;
    logic [1:0]  req_mode = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        r32, v32, ades32;
    logic [31:0] a32, d32;
    logic [3:0]  s32;
    logic [2:0]  c32;
    logic        r64, v64, ades64;
    logic [31:0] a64;
    logic [63:0] d64;
    logic [7:0]  s64;
    logic [2:0]  c64;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    store_align_queue #(.DATA_W(32), .DEPTH(4), .ADDR_W(32)) dut32 (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(r32),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size), .req_mode(req_mode),
        .flush(flush), .out_valid(v32), .out_ready(out_ready), .out_addr(a32),
        .out_data(d32), .out_strb(s32), .ades(ades32), .count(c32)
    );

    store_align_queue #(.DATA_W(64), .DEPTH(4), .ADDR_W(32)) dut64 (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(r64),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size), .req_mode(req_mode),
        .flush(flush), .out_valid(v64), .out_ready(out_ready), .out_addr(a64),
        .out_data(d64), .out_strb(s64), .ades(ades64), .count(c64)
    );

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
    } ent_t;

    ent_t q32[$];
    ent_t q64[$];
    bit   ades_e32, ades_e64;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Byte-by-byte view: which register byte lands in which memory lane.
    function automatic void model_align(input int dw, input logic [31:0] addr,
                                        input logic [31:0] data, input logic [1:0] size,
                                        input logic [1:0] mode, output ent_t e, output bit ill);
        int o, w, nb, src;
        bit en;
        o = int'(addr[1:0]);
        w = (dw == 64) ? int'(addr[2]) : 0;
        e.addr = (dw == 64) ? {addr[31:3], 3'b000} : {addr[31:2], 2'b00};
        e.data = '0;
        e.strb = '0;
        ill = 0;
        nb = 0;
        if (mode == 2'd0) begin
            if (size == 2'd0) nb = 1;
            else if (size == 2'd1) begin nb = 2; ill = (o % 2) != 0; end
            else if (size == 2'd2) begin nb = 4; ill = (o != 0); end
            else ill = 1;
        end else if (mode == 2'd3) begin
            ill = 1;
        end
        for (int i = 0; i < 4; i++) begin
            en = 0;
            src = 0;
            if (mode == 2'd0) begin en = (i >= o) && (i < o + nb); src = i - o; end
            else if (mode == 2'd1) begin en = (i <= o); src = 3 - o + i; end
            else if (mode == 2'd2) begin en = (i >= o); src = i - o; end
            if (en) begin
                e.data[32*w + 8*i +: 8] = data[8*src +: 8];
                e.strb[4*w + i] = 1'b1;
            end
        end
    endfunction

    always @(posedge clk or negedge resetn) begin
        ent_t e;
        bit ill, acc, pop;
        if (!resetn) begin
            q32.delete();
            q64.delete();
            ades_e32 = 0;
            ades_e64 = 0;
        end else begin
            model_align(32, req_addr, req_data, req_size, req_mode, e, ill);
            acc = req_valid && (q32.size() < 4);
            pop = (q32.size() != 0) && out_ready;
            ades_e32 = acc && ill;
            if (flush) q32.delete();
            else begin
                if (pop) void'(q32.pop_front());
                if (acc && !ill) q32.push_back(e);
            end

            model_align(64, req_addr, req_data, req_size, req_mode, e, ill);
            acc = req_valid && (q64.size() < 4);
            pop = (q64.size() != 0) && out_ready;
            ades_e64 = acc && ill;
            if (flush) q64.delete();
            else begin
                if (pop) void'(q64.pop_front());
                if (acc && !ill) q64.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        chk("ready32", {63'h0, r32}, {63'h0, q32.size() < 4});
        chk("valid32", {63'h0, v32}, {63'h0, q32.size() != 0});
        chk("count32", {61'h0, c32}, 64'(q32.size()));
        chk("ades32",  {63'h0, ades32}, {63'h0, ades_e32});
        if (q32.size() != 0) begin
            chk("addr32", {32'h0, a32}, {32'h0, q32[0].addr});
            chk("data32", {32'h0, d32}, q32[0].data);
            chk("strb32", {60'h0, s32}, {56'h0, q32[0].strb});
        end
        chk("ready64", {63'h0, r64}, {63'h0, q64.size() < 4});
        chk("valid64", {63'h0, v64}, {63'h0, q64.size() != 0});
        chk("count64", {61'h0, c64}, 64'(q64.size()));
        chk("ades64",  {63'h0, ades64}, {63'h0, ades_e64});
        if (q64.size() != 0) begin
            chk("addr64", {32'h0, a64}, {32'h0, q64[0].addr});
            chk("data64", d64, q64[0].data);
            chk("strb64", {56'h0, s64}, {56'h0, q64[0].strb});
        end
    end

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic [1:0] md, input logic fl);
        @(posedge clk);
        #1;
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        req_size  = sz;
        req_mode  = md;
        flush     = fl;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, SZ_BYTE, MD_NORM, 1'b0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  sz;
        logic [1:0]  md;
        logic        rdy;
    } vec_t;

    vec_t vecs[$];

    initial begin
        ent_t pe;
        bit   pill;

        model_align(32, 32'h1003, 32'h000000AB, SZ_BYTE, MD_NORM, pe, pill);
        chk("pin_byte_data", pe.data, 64'hAB000000);
        chk("pin_byte_strb", {56'h0, pe.strb}, 64'h8);
        model_align(64, 32'h2006, 32'h0000BEEF, SZ_HALF, MD_NORM, pe, pill);
        chk("pin_half64_data", pe.data, 64'hBEEF0000_00000000);
        chk("pin_half64_strb", {56'h0, pe.strb}, 64'hC0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_count", {61'h0, c32}, 64'h0);
        chk("rst_valid", {63'h0, v64}, 64'h0);
        @(posedge clk);
        #2 resetn = 1'b1;
        out_ready = 1'b1;

        drive(1'b1, 32'h1003, 32'h000000AB, SZ_BYTE, MD_NORM, 1'b0);
        idle();
        @(negedge clk);
        chk("byte_data", {32'h0, d32}, 64'hAB000000);
        chk("byte_strb", {60'h0, s32}, 64'h8);
        chk("byte_addr", {32'h0, a32}, 64'h1000);
        chk("byte_valid", {63'h0, v32}, 64'h1);

        drive(1'b1, 32'h4001, 32'h11223344, SZ_WORD, MD_SWL, 1'b0);
        idle();
        @(negedge clk);
        chk("swl_data", {32'h0, d32}, 64'h00001122);
        chk("swl_strb", {60'h0, s32}, 64'h3);

        drive(1'b1, 32'h4001, 32'h11223344, SZ_BYTE, MD_SWR, 1'b0);
        idle();
        @(negedge clk);
        chk("swr_data", {32'h0, d32}, 64'h22334400);
        chk("swr_strb", {60'h0, s32}, 64'hE);

        drive(1'b1, 32'h2006, 32'h0000BEEF, SZ_HALF, MD_NORM, 1'b0);
        idle();
        @(negedge clk);
        chk("half64_data", d64, 64'hBEEF0000_00000000);
        chk("half64_strb", {56'h0, s64}, 64'hC0);
        chk("half64_addr", {32'h0, a64}, 64'h2000);
        chk("half32_data", {32'h0, d32}, 64'hBEEF0000);

        drive(1'b1, 32'h3002, 32'hCAFEF00D, SZ_WORD, MD_NORM, 1'b0);
        idle();
        @(negedge clk);
        chk("ades_pulse", {63'h0, ades32}, 64'h1);
        chk("ades_count", {61'h0, c32}, 64'h0);
        chk("ades_valid", {63'h0, v32}, 64'h0);
        @(negedge clk);
        chk("ades_drop", {63'h0, ades32}, 64'h0);

        vecs = '{
            '{32'h0000_0100, 32'hA1B2C3D4, SZ_BYTE, MD_NORM, 1'b1},
            '{32'h0000_0105, 32'hA1B2C3D4, SZ_BYTE, MD_NORM, 1'b0},
            '{32'h0000_0101, 32'h0000BEEF, SZ_HALF, MD_NORM, 1'b0},
            '{32'h0000_0104, 32'hDEADBEEF, SZ_WORD, MD_NORM, 1'b1},
            '{32'h0000_0108, 32'h55667788, SZ_WORD, MD_SWL,  1'b0},
            '{32'h0000_010F, 32'h55667788, SZ_HALF, MD_SWL,  1'b1},
            '{32'h0000_010C, 32'h99AABBCC, SZ_BYTE, MD_SWR,  1'b1},
            '{32'h0000_010B, 32'h99AABBCC, SZ_WORD, MD_SWR,  1'b0},
            '{32'h0000_0110, 32'h12345678, SZ_WORD, 2'd3,    1'b1},
            '{32'h0000_0112, 32'h12345678, SZ_HALF, MD_NORM, 1'b1},
            '{32'h0000_0110, 32'h12345678, 2'd3,    MD_NORM, 1'b0},
            '{32'h0000_0116, 32'h0BADF00D, SZ_HALF, MD_NORM, 1'b1}
        };
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].a, vecs[i].d, vecs[i].sz, vecs[i].md, 1'b0);
            out_ready = vecs[i].rdy;
        end
        out_ready = 1'b1;
        repeat (6) idle();

        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h5000 + 32'(4*i), 32'h100 + 32'(i), SZ_WORD, MD_NORM, 1'b0);
        end
        @(negedge clk);
        chk("full_count", {61'h0, c32}, 64'h4);
        chk("full_ready", {63'h0, r32}, 64'h0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h6000 + 32'(4*i), 32'h200 + 32'(i), SZ_WORD, MD_NORM, 1'b0);
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk("steady_count", {61'h0, c32}, 64'h3);
        repeat (6) idle();

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h7000 + 32'(4*i), 32'h300 + 32'(i), SZ_WORD, MD_NORM, 1'b0);
        end
        drive(1'b1, 32'h7010, 32'h399, SZ_WORD, MD_NORM, 1'b1);
        idle();
        @(negedge clk);
        chk("flush_count", {61'h0, c32}, 64'h0);
        chk("flush_valid", {63'h0, v64}, 64'h0);

        drive(1'b1, 32'h3002, 32'h1, SZ_WORD, MD_NORM, 1'b1);
        idle();
        @(negedge clk);
        chk("flush_ades", {63'h0, ades32}, 64'h1);

        drive(1'b1, 32'h8000, 32'h400, SZ_WORD, MD_NORM, 1'b0);
        drive(1'b1, 32'h8004, 32'h401, SZ_WORD, MD_NORM, 1'b0);
        idle();
        @(negedge clk);
        chk("pre_rst_count", {61'h0, c32}, 64'h2);
        @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("async_rst_count", {61'h0, c32}, 64'h0);
        chk("async_rst_valid", {63'h0, v64}, 64'h0);
        @(posedge clk);
        #2 resetn = 1'b1;

        out_ready = 1'b1;
        drive(1'b1, 32'h9007, 32'h000000EE, SZ_BYTE, MD_NORM, 1'b0);
        repeat (4) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/store_align_queue.md
STORE_ALIGN_QUEUE -- requirements
Module: store_align_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 32, memory data bus width in bits (32 or 64).
REQ-002 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-003 SHALL have parameter ADDR_W, default 32, address width.
REQ-004 SHALL use one clock; reset is asynchronous and active-low; ports are clk and resetn.
REQ-005 Ports SHALL be:
- clk  in  1  clock
- resetn  in  1  async active-low reset
- req_valid  in  1  store request present
- req_ready  out  1  queue can accept
- req_addr  in  ADDR_W  byte address
- req_data  in  32  register (rt) value, unshifted
- req_size  in  2  0 byte, 1 half, 2 word
- req_mode  in  2  0 normal, 1 SWL, 2 SWR
- flush  in  1  discard all queued entries
- out_valid  out  1  head entry valid
- out_ready  in  1  memory side accepts head
- out_addr  out  ADDR_W  req_addr with low log2(DATA_W/8) bits cleared
- out_data  out  DATA_W  lane-aligned data
- out_strb  out  DATA_W/8  byte enables
- ades  out  1  one-cycle address-error pulse
- count  out  log2(DEPTH)+1  occupancy

Function
REQ-006 Byte offset o = req_addr[1:0]; word lane w = req_addr[2] when DATA_W=64, else 0; all shifts below are within the 32-bit word, then placed in lane w.
REQ-007 Normal byte: data = req_data << 8*o, strb = 4'b0001 << o.
REQ-008 Normal half: requires o[0]=0; data = req_data << 8*o, strb = 4'b0011 << o.
REQ-009 Normal word: requires o=0; data = req_data, strb = 4'b1111.
REQ-010 SWL (little-endian): data = req_data >> 8*(3-o), strb = (1<<(o+1))-1; req_size ignored.
REQ-011 SWR: data = req_data << 8*o, strb = 4'b1111 << o (truncated to 4 bits); req_size ignored.
REQ-012 Byte lanes with strb=0 SHALL carry 0 in out_data.
REQ-013 Misaligned normal half/word, or req_mode=3, SHALL be consumed when req_valid&req_ready, not enqueued, and SHALL assert ades for exactly the following cycle.
REQ-014 req_ready SHALL equal !full, with no combinational dependence on out_ready.
REQ-015 Push occurs on req_valid&req_ready for a legal request; pop on out_valid&out_ready.
REQ-016 Latency: entry pushed in cycle N SHALL appear at the outputs (if it is head) in cycle N+1; empty queue SHALL hold out_valid=0.
REQ-017 Simultaneous push and pop SHALL keep count unchanged; push while full is impossible (req_ready=0).
REQ-018 Read/write pointers SHALL wrap modulo DEPTH; full when count=DEPTH, empty when count=0.
REQ-019 out_* SHALL remain stable while out_valid&!out_ready.
REQ-020 flush SHALL, at the next edge, set count=0 and out_valid=0; flush beats push and pop in the same cycle; ades from a same-cycle illegal request still fires.

Reset
REQ-021 While resetn=0: pointers=0, count=0, out_valid=0, ades=0, req_ready=1 after release; storage contents unspecified.
REQ-022 Reset asserted mid-operation SHALL discard all entries immediately (asynchronously).

Structure
REQ-023 Package store_pkg SHALL hold size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), mode encodings (MD_NORM/MD_SWL/MD_SWR), and function for LANES=DATA_W/8.
REQ-024 Combinational alignment (REQ-006..013) SHALL be sub-module store_lane_align; queue logic lives in store_align_queue.

Verification
REQ-025 Byte, DATA_W=32: addr=0x1003, data=0x000000AB -> out_data=0xAB000000, strb=4'b1000, out_addr=0x1000, next cycle.
REQ-026 SWL/SWR: data=0x11223344, addr=...1: SWL -> data=0x00001122, strb=0011; SWR -> data=0x22334400, strb=1110.
REQ-027 DATA_W=64 half at addr=0x2006, data=0xBEEF -> out_data=0xBEEF0000_00000000, strb=8'b11000000, out_addr=0x2000.
REQ-028 Word at addr=0x3002 -> ades pulses one cycle, count stays 0, out_valid stays 0.
REQ-029 DEPTH=4, out_ready=0, push 5 -> req_ready=0 after 4th, count=4; then out_ready=1 with pushes -> FIFO order preserved, count steady.
REQ-030 Queue holding 3 entries, flush and legal push same cycle -> next cycle count=0, out_valid=0; resetn low mid-stream -> count=0 immediately.
